// File: rtl/pc_unit_if.sv
// Bundle of the PC unit's control inputs and fetch/exception outputs.
// The master modport belongs to the decode/branch side and the slave modport to the PC unit.
interface pc_unit_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            jump;
  logic [XLEN-1:0] jump_target;
  logic            trap;
  logic            mret;
  logic            halt_req;
  logic            resume;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus;
  logic [XLEN-1:0] epc_out;
  logic            fetch_valid;
  logic            misaligned;
  logic            halted;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target,
           trap, mret, halt_req, resume,
    input  pc_out, pc_plus, epc_out, fetch_valid, misaligned, halted
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target,
           trap, mret, halt_req, resume,
    output pc_out, pc_plus, epc_out, fetch_valid, misaligned, halted
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: fetch PC, next-PC selection, exception PC, and halt control.
// All state changes happen on the falling clock edge; reset clears everything asynchronously.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              INC          = 4,
  parameter int              ALIGN_BITS   = 2
) (
  input  logic     clk,
  input  logic     reset,
  pc_unit_if.slave bus
);
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_epc;
  logic            r_fetch_valid;
  logic            r_misaligned;
  logic            r_halted;

  state_t          w_state_next;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_epc_next;
  logic            w_fetch_valid_next;
  logic            w_misaligned_next;
  logic            w_halted_next;

  logic [XLEN-1:0] w_pc_plus;
  logic            w_jump_ok;
  logic            w_branch_ok;

  assign w_pc_plus   = r_pc + INC_V;
  assign w_jump_ok   = (bus.jump_target & ALIGN_MASK) == '0;
  assign w_branch_ok = (bus.branch_target & ALIGN_MASK) == '0;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_BOOT;
      r_pc          <= '0;
      r_epc         <= '0;
      r_fetch_valid <= 1'b0;
      r_misaligned  <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_epc         <= w_epc_next;
      r_fetch_valid <= w_fetch_valid_next;
      r_misaligned  <= w_misaligned_next;
      r_halted      <= w_halted_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_epc_next         = r_epc;
    w_fetch_valid_next = r_fetch_valid;
    w_misaligned_next  = 1'b0;
    w_halted_next      = r_halted;

    case (r_state)
      S_BOOT: begin
        w_pc_next          = RESET_VECTOR;
        w_fetch_valid_next = 1'b1;
        w_state_next       = S_RUN;
      end
      S_RUN: begin
        // A misaligned jump/branch is handled like a trap, plus the one-cycle flag.
        if (bus.trap) begin
          w_epc_next = r_pc;
          w_pc_next  = TRAP_VECTOR;
        end else if (bus.mret) begin
          w_pc_next = r_epc;
        end else if (bus.jump) begin
          if (w_jump_ok) begin
            w_pc_next = bus.jump_target;
          end else begin
            w_epc_next        = r_pc;
            w_pc_next         = TRAP_VECTOR;
            w_misaligned_next = 1'b1;
          end
        end else if (bus.branch_taken) begin
          if (w_branch_ok) begin
            w_pc_next = bus.branch_target;
          end else begin
            w_epc_next        = r_pc;
            w_pc_next         = TRAP_VECTOR;
            w_misaligned_next = 1'b1;
          end
        end else if (!bus.stall) begin
          w_pc_next = w_pc_plus;
        end

        if (bus.halt_req) begin
          w_state_next       = S_HALT;
          w_halted_next      = 1'b1;
          w_fetch_valid_next = 1'b0;
        end
      end
      S_HALT: begin
        if (bus.resume && !bus.halt_req) begin
          w_state_next       = S_RUN;
          w_halted_next      = 1'b0;
          w_fetch_valid_next = 1'b1;
        end
      end
      default: begin
        w_state_next = S_BOOT;
      end
    endcase
  end

  assign bus.pc_out      = r_pc;
  assign bus.pc_plus     = w_pc_plus;
  assign bus.epc_out     = r_epc;
  assign bus.fetch_valid = r_fetch_valid;
  assign bus.misaligned  = r_misaligned;
  assign bus.halted      = r_halted;
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: stimulus pushes hand-computed expected states into a queue,
// a monitor pops each entry and compares it with the DUT outputs at that moment.
module tb_pc_unit;
  logic clk;
  logic reset;

  pc_unit_if #(.XLEN(32)) bus32 ();
  pc_unit_if #(.XLEN(8))  bus8 ();

  pc_unit #(
    .XLEN(32), .RESET_VECTOR(32'h0000_0000), .TRAP_VECTOR(32'h0000_0100),
    .INC(4), .ALIGN_BITS(2)
  ) dut32 (
    .clk(clk), .reset(reset), .bus(bus32.slave)
  );

  pc_unit #(
    .XLEN(8), .RESET_VECTOR(8'hF8), .TRAP_VECTOR(8'h10),
    .INC(4), .ALIGN_BITS(2)
  ) dut8 (
    .clk(clk), .reset(reset), .bus(bus8.slave)
  );

  typedef struct {
    string       name;
    int          dut;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic [31:0] epc;
    logic        fv;
    logic        mis;
    logic        halted;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Monitor: compares every queued expectation against the selected DUT.
  initial begin
    forever begin
      exp_t        e;
      logic [31:0] a_pc, a_plus, a_epc;
      logic        a_fv, a_mis, a_hl;
      wait (sb_q.size() != 0);
      e = sb_q.pop_front();
      if (e.dut == 0) begin
        a_pc = bus32.pc_out; a_plus = bus32.pc_plus; a_epc = bus32.epc_out;
        a_fv = bus32.fetch_valid; a_mis = bus32.misaligned; a_hl = bus32.halted;
      end else begin
        a_pc = {24'h0, bus8.pc_out}; a_plus = {24'h0, bus8.pc_plus};
        a_epc = {24'h0, bus8.epc_out};
        a_fv = bus8.fetch_valid; a_mis = bus8.misaligned; a_hl = bus8.halted;
      end
      checks++;
      if ({a_pc, a_plus, a_epc, a_fv, a_mis, a_hl} !==
          {e.pc, e.pc_plus, e.epc, e.fv, e.mis, e.halted}) begin
        failures++;
        $display("FAIL %s: got pc=%h plus=%h epc=%h fv=%b mis=%b halted=%b, expected pc=%h plus=%h epc=%h fv=%b mis=%b halted=%b",
                 e.name, a_pc, a_plus, a_epc, a_fv, a_mis, a_hl,
                 e.pc, e.pc_plus, e.epc, e.fv, e.mis, e.halted);
      end else begin
        $display("ok   %s: pc=%h epc=%h fv=%b mis=%b halted=%b",
                 e.name, a_pc, a_epc, a_fv, a_mis, a_hl);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input int d, input logic [31:0] pc,
                     input logic [31:0] epc, input logic fv, input logic mis,
                     input logic hl);
    exp_t e;
    e.name = n; e.dut = d; e.pc = pc; e.epc = epc;
    e.fv = fv; e.mis = mis; e.halted = hl;
    e.pc_plus = (d == 0) ? pc + 32'd4 : ((pc + 32'd4) & 32'h0000_00FF);
    sb_q.push_back(e);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus32.stall = 0; bus32.branch_taken = 0; bus32.branch_target = '0;
    bus32.jump = 0; bus32.jump_target = '0; bus32.trap = 0; bus32.mret = 0;
    bus32.halt_req = 0; bus32.resume = 0;
    bus8.stall = 0; bus8.branch_taken = 0; bus8.branch_target = '0;
    bus8.jump = 0; bus8.jump_target = '0; bus8.trap = 0; bus8.mret = 0;
    bus8.halt_req = 0; bus8.resume = 0;

    // Reset held with clock running
    neg();                 chk("rst_neg", 0, 32'h0, 32'h0, 0, 0, 0);
    @(posedge clk); #1;    chk("rst_pos", 0, 32'h0, 32'h0, 0, 0, 0);
    neg();                 chk("rst_neg2", 0, 32'h0, 32'h0, 0, 0, 0);
                           chk("rst8", 1, 32'h0, 32'h0, 0, 0, 0);
    reset = 1'b0;

    // Boot and increment, plus 8-bit wrap
    neg();  chk("boot", 0, 32'h0, 32'h0, 1, 0, 0);
            chk("boot8", 1, 32'hF8, 32'h0, 1, 0, 0);
    neg();  chk("inc4", 0, 32'h4, 32'h0, 1, 0, 0);
            chk("inc8_fc", 1, 32'hFC, 32'h0, 1, 0, 0);
    neg();  chk("inc8", 0, 32'h8, 32'h0, 1, 0, 0);
            chk("wrap8_00", 1, 32'h00, 32'h0, 1, 0, 0);
    @(posedge clk); #1; chk("posedge_hold", 0, 32'h8, 32'h0, 1, 0, 0);
    neg();  chk("inc12", 0, 32'hC, 32'h0, 1, 0, 0);
            chk("inc8_04", 1, 32'h04, 32'h0, 1, 0, 0);

    // Stall
    bus32.stall = 1;
    for (int i = 0; i < 3; i++) begin
      neg(); chk($sformatf("stall%0d", i), 0, 32'hC, 32'h0, 1, 0, 0);
    end
    bus32.stall = 0;

    // Jump beats branch; misaligned redirects
    bus32.branch_taken = 1; bus32.branch_target = 32'h40;
    bus32.jump = 1; bus32.jump_target = 32'h80;
    neg(); chk("jump_over_branch", 0, 32'h80, 32'h0, 1, 0, 0);
    bus32.branch_taken = 0; bus32.jump_target = 32'h82;
    neg(); chk("jump_misaligned", 0, 32'h100, 32'h80, 1, 1, 0);
    bus32.jump = 0;
    neg(); chk("mis_pulse_end", 0, 32'h104, 32'h80, 1, 0, 0);
    bus32.branch_taken = 1; bus32.branch_target = 32'h42;
    neg(); chk("branch_misaligned", 0, 32'h100, 32'h104, 1, 1, 0);
    bus32.branch_target = 32'h40;
    neg(); chk("branch_ok", 0, 32'h40, 32'h104, 1, 0, 0);
    bus32.branch_taken = 0;

    // Trap / mret
    bus32.jump = 1; bus32.jump_target = 32'h20;
    neg(); chk("jump_20", 0, 32'h20, 32'h104, 1, 0, 0);
    bus32.jump = 0; bus32.trap = 1;
    neg(); chk("trap", 0, 32'h100, 32'h20, 1, 0, 0);
    bus32.trap = 0; bus32.mret = 1;
    neg(); chk("mret", 0, 32'h20, 32'h20, 1, 0, 0);
    bus32.mret = 0;
    neg(); chk("after_mret", 0, 32'h24, 32'h20, 1, 0, 0);
    bus32.trap = 1; bus32.jump = 1; bus32.jump_target = 32'h83;
    neg(); chk("trap_over_misjump", 0, 32'h100, 32'h24, 1, 0, 0);
    bus32.trap = 0; bus32.jump = 0; bus32.mret = 1;
    neg(); chk("mret2", 0, 32'h24, 32'h24, 1, 0, 0);
    bus32.mret = 0;

    // Halt / resume
    bus32.jump = 1; bus32.jump_target = 32'h10;
    neg(); chk("jump_10", 0, 32'h10, 32'h24, 1, 0, 0);
    bus32.jump = 0; bus32.halt_req = 1;
    neg(); chk("halt_enter", 0, 32'h14, 32'h24, 0, 0, 1);
    bus32.halt_req = 0; bus32.jump = 1; bus32.jump_target = 32'h40;
    neg(); chk("halt_ignores_jump", 0, 32'h14, 32'h24, 0, 0, 1);
    bus32.jump = 0; bus32.halt_req = 1; bus32.resume = 1;
    neg(); chk("halt_and_resume", 0, 32'h14, 32'h24, 0, 0, 1);
    bus32.halt_req = 0;
    neg(); chk("resume", 0, 32'h14, 32'h24, 1, 0, 0);
    bus32.resume = 0;
    neg(); chk("run_after_resume", 0, 32'h18, 32'h24, 1, 0, 0);

    // Asynchronous reset mid-cycle, then boot again
    reset = 1'b1;
    #1;    chk("async_reset", 0, 32'h0, 32'h0, 0, 0, 0);
    reset = 1'b0;
    neg(); chk("reboot", 0, 32'h0, 32'h0, 1, 0, 0);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
